board_io_ctrl: RTL

- Memory-mapped I/O peripheral on the CPU data bus, selected when address bit 8 is set (I/O region 0x100–0x1FF).
- Owns the board-facing registers: LED, HEX value, debounced switches, debounced keys with sticky press flags, and a 32-bit timer with compare flag.
- Produces the I/O read data that the top-level read mux selects against RAM data.
- Drives LEDR and the value fed to the six dec7seg instances.

---
 rtl/board_io_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: memory-mapped board I/O block (LED, HEX, switches, keys, 32-bit timer).
// Define DEBOUNCE_EN to place per-bit debounce counters after the input synchronizers.
module board_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SW_W            = 10,
  parameter int KEY_W           = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             io_sel,
  input  logic             wr_en,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [KEY_W-1:0] key_n,
  output logic [9:0]       led_out,
  output logic [23:0]      hex_value,
  output logic             timer_flag
);
  localparam logic [5:0] REG_LED   = 6'h00;
  localparam logic [5:0] REG_HEX   = 6'h01;
  localparam logic [5:0] REG_KEY   = 6'h02;
  localparam logic [5:0] REG_TCNT  = 6'h04;
  localparam logic [5:0] REG_TCMP  = 6'h05;
  localparam logic [5:0] REG_TCTRL = 6'h06;
  localparam logic [5:0] REG_SW    = 6'h08;

  logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic [KEY_W-1:0] key_meta_q, key_meta_d, key_sync_q, key_sync_d;
  logic [SW_W-1:0]  sw_db;
  logic [KEY_W-1:0] key_db, key_db_next;

  logic [9:0]       led_q, led_d;
  logic [23:0]      hex_q, hex_d;
  logic [KEY_W-1:0] key_flag_q, key_flag_d;
  logic [31:0]      tcnt_q, tcnt_d, tcmp_q, tcmp_d;
  logic             en_q, en_d, flag_q, flag_d, arl_q, arl_d;

  logic       wr;
  logic [5:0] reg_idx;
  logic       tcnt_hit;
  logic       unused_addr_lsbs;

  assign wr               = io_sel && wr_en;
  assign reg_idx          = addr[7:2];
  assign tcnt_hit         = en_q && (tcnt_q == tcmp_q);
  assign unused_addr_lsbs = ^addr[1:0];

  // Keys are inverted on entry so everything downstream sees pressed=1.
  always_comb begin
    sw_meta_d  = sw_in;
    sw_sync_d  = sw_meta_q;
    key_meta_d = ~key_n;
    key_sync_d = key_meta_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '0;
      key_sync_q <= '0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0][CNT_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [KEY_W-1:0][CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic [SW_W-1:0]             sw_stable_q, sw_stable_d;
  logic [KEY_W-1:0]            key_stable_q, key_stable_d;

  // A bit only moves once its synced value has disagreed for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    sw_cnt_d     = sw_cnt_q;
    sw_stable_d  = sw_stable_q;
    key_cnt_d    = key_cnt_q;
    key_stable_d = key_stable_q;
    for (int i = 0; i < SW_W; i++) begin
      if (sw_sync_q[i] == sw_stable_q[i]) begin
        sw_cnt_d[i] = '0;
      end else if (sw_cnt_q[i] == CNT_MAX) begin
        sw_stable_d[i] = sw_sync_q[i];
        sw_cnt_d[i]    = '0;
      end else begin
        sw_cnt_d[i] = sw_cnt_q[i] + 1'b1;
      end
    end
    for (int i = 0; i < KEY_W; i++) begin
      if (key_sync_q[i] == key_stable_q[i]) begin
        key_cnt_d[i] = '0;
      end else if (key_cnt_q[i] == CNT_MAX) begin
        key_stable_d[i] = key_sync_q[i];
        key_cnt_d[i]    = '0;
      end else begin
        key_cnt_d[i] = key_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_cnt_q     <= '0;
      key_cnt_q    <= '0;
      sw_stable_q  <= '0;
      key_stable_q <= '0;
    end else begin
      sw_cnt_q     <= sw_cnt_d;
      key_cnt_q    <= key_cnt_d;
      sw_stable_q  <= sw_stable_d;
      key_stable_q <= key_stable_d;
    end
  end

  assign sw_db       = sw_stable_q;
  assign key_db      = key_stable_q;
  assign key_db_next = key_stable_d;
`else
  assign sw_db       = sw_sync_q;
  assign key_db      = key_sync_q;
  assign key_db_next = key_sync_d;
`endif

  // Sticky flags and the timer flag: a same-cycle set beats a write-1-to-clear.
  always_comb begin
    led_d      = led_q;
    hex_d      = hex_q;
    key_flag_d = key_flag_q;
    tcmp_d     = tcmp_q;
    en_d       = en_q;
    arl_d      = arl_q;
    flag_d     = flag_q;
    tcnt_d     = tcnt_q;
    if (en_q) begin
      tcnt_d = (tcnt_hit && arl_q) ? 32'd0 : tcnt_q + 32'd1;
    end
    if (wr) begin
      case (reg_idx)
        REG_LED:   led_d = wdata[9:0];
        REG_HEX:   hex_d = wdata[23:0];
        REG_KEY:   key_flag_d = key_flag_q & ~wdata[4 +: KEY_W];
        REG_TCMP:  tcmp_d = wdata;
        REG_TCTRL: begin
          en_d  = wdata[0];
          arl_d = wdata[2];
          if (wdata[1]) flag_d = 1'b0;
        end
        default: ;
      endcase
    end
    key_flag_d = key_flag_d | (key_db_next & ~key_db);
    if (tcnt_hit) flag_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      led_q      <= '0;
      hex_q      <= '0;
      key_flag_q <= '0;
      tcnt_q     <= '0;
      tcmp_q     <= '1;
      en_q       <= 1'b0;
      arl_q      <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      led_q      <= led_d;
      hex_q      <= hex_d;
      key_flag_q <= key_flag_d;
      tcnt_q     <= tcnt_d;
      tcmp_q     <= tcmp_d;
      en_q       <= en_d;
      arl_q      <= arl_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_LED:   rdata[9:0] = led_q;
      REG_HEX:   rdata[23:0] = hex_q;
      REG_KEY: begin
        rdata[KEY_W-1:0] = key_db;
        rdata[4 +: KEY_W] = key_flag_q;
      end
      REG_TCNT:  rdata = tcnt_q;
      REG_TCMP:  rdata = tcmp_q;
      REG_TCTRL: rdata[2:0] = {arl_q, flag_q, en_q};
      REG_SW:    rdata[SW_W-1:0] = sw_db;
      default: ;
    endcase
  end

  assign led_out    = led_q;
  assign hex_value  = hex_q;
  assign timer_flag = flag_q;
endmodule
